// File: rtl/scene_int_ctrl.sv
// rtl/scene_int_ctrl.sv - issue/collect controller around the scene bounding-box intersection pipeline
// Sequences x/y/z issue cycles, tracks tags through the fixed-latency pipeline and returns results in order.
module scene_int_ctrl #(
   parameter int RAY_W = 192,
   parameter int TAG_W = 8,
   parameter int LAT   = 24,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ray_in_valid,
   output logic             ray_in_stall,
   input  logic [RAY_W-1:0] ray_in,
   input  logic [TAG_W-1:0] ray_in_tag,
   input  logic             ray_in_isShadow,
   output logic [RAY_W-1:0] sint_ray,
   output logic             sint_v0,
   output logic             sint_v1,
   output logic             sint_v2,
   output logic             sint_isShadow,
   input  logic [31:0]      sint_tmin,
   input  logic [31:0]      sint_tmax,
   input  logic             sint_miss,
   output logic             hit_valid,
   input  logic             hit_stall,
   output logic [TAG_W-1:0] hit_tag,
   output logic [31:0]      hit_tmin,
   output logic [31:0]      hit_tmax,
   output logic             hit_isShadow,
   output logic             miss_valid,
   input  logic             miss_stall,
   output logic [TAG_W-1:0] miss_tag
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, AX_X, AX_Y, AX_Z} state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             shadow;
      logic [31:0]      tmin;
      logic [31:0]      tmax;
      logic             miss;
   } res_t;

   state_t           state;
   logic [CW-1:0]    credits;
   logic [TAG_W-1:0] held_tag;
   logic             accept;
   logic             push;
   logic             pop;

   logic [LAT-1:0]   dl_valid;
   logic [TAG_W-1:0] dl_tag    [LAT];
   logic             dl_shadow [LAT];

   res_t             mem [DEPTH];
   res_t             head;
   res_t             entry;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             empty;

   // A new ray may only start when the previous one has finished its z cycle and a result slot is reserved.
   assign ray_in_stall = !(((state == IDLE) || (state == AX_Z)) && (credits != '0));
   assign accept       = ray_in_valid && !ray_in_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sint_v0       <= 1'b0;
         sint_v1       <= 1'b0;
         sint_v2       <= 1'b0;
         sint_ray      <= '0;
         sint_isShadow <= 1'b0;
         held_tag      <= '0;
      end else begin
         case (state)
            AX_X: begin
               state   <= AX_Y;
               sint_v0 <= 1'b0;
               sint_v1 <= 1'b1;
               sint_v2 <= 1'b0;
            end
            AX_Y: begin
               state   <= AX_Z;
               sint_v0 <= 1'b0;
               sint_v1 <= 1'b0;
               sint_v2 <= 1'b1;
            end
            default: begin
               if (accept) begin
                  state   <= AX_X;
                  sint_v0 <= 1'b1;
               end else begin
                  state   <= IDLE;
                  sint_v0 <= 1'b0;
               end
               sint_v1 <= 1'b0;
               sint_v2 <= 1'b0;
            end
         endcase
         if (accept) begin
            sint_ray      <= ray_in;
            sint_isShadow <= ray_in_isShadow;
            held_tag      <= ray_in_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CW'(DEPTH);
      end else if (accept && !pop) begin
         credits <= credits - CW'(1);
      end else if (!accept && pop) begin
         credits <= credits + CW'(1);
      end
   end

   // Only the valid bits need clearing on reset; stale tags behind a zero valid are never pushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_valid <= '0;
      end else begin
         dl_valid <= {dl_valid[LAT-2:0], (state == AX_X)};
      end
   end

   always_ff @(posedge clk) begin
      dl_tag[0]    <= held_tag;
      dl_shadow[0] <= sint_isShadow;
      for (int i = 1; i < LAT; i++) begin
         dl_tag[i]    <= dl_tag[i-1];
         dl_shadow[i] <= dl_shadow[i-1];
      end
   end

   assign push       = dl_valid[LAT-1];
   assign entry.tag    = dl_tag[LAT-1];
   assign entry.shadow = dl_shadow[LAT-1];
   assign entry.tmin   = sint_tmin;
   assign entry.tmax   = sint_tmax;
   assign entry.miss   = sint_miss;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         assert (!(push && (count == CW'(DEPTH))));
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign empty        = (count == '0);
   assign head         = mem[rd_ptr];
   assign hit_valid    = !empty && !head.miss;
   assign miss_valid   = !empty && head.miss;
   assign hit_tag      = head.tag;
   assign hit_tmin     = head.tmin;
   assign hit_tmax     = head.tmax;
   assign hit_isShadow = head.shadow;
   assign miss_tag     = head.tag;
   assign pop          = (hit_valid && !hit_stall) || (miss_valid && !miss_stall);

endmodule

// File: tb/tb_scene_int_ctrl.sv
// tb/tb_scene_int_ctrl.sv - scoreboard bench for scene_int_ctrl
// Directed rays with hand-chosen results; a negedge monitor pops and compares every delivered result.
module tb_scene_int_ctrl;
   localparam int RAY_W = 192;
   localparam int TAG_W = 8;
   localparam int LAT   = 24;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             ray_in_valid;
   logic             ray_in_stall;
   logic [RAY_W-1:0] ray_in;
   logic [TAG_W-1:0] ray_in_tag;
   logic             ray_in_isShadow;
   logic [RAY_W-1:0] sint_ray;
   logic             sint_v0, sint_v1, sint_v2, sint_isShadow;
   logic [31:0]      sint_tmin, sint_tmax;
   logic             sint_miss;
   logic             hit_valid, hit_stall, hit_isShadow;
   logic [TAG_W-1:0] hit_tag, miss_tag;
   logic [31:0]      hit_tmin, hit_tmax;
   logic             miss_valid, miss_stall;

   scene_int_ctrl #(.RAY_W(RAY_W), .TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .ray_in_valid(ray_in_valid), .ray_in_stall(ray_in_stall), .ray_in(ray_in),
      .ray_in_tag(ray_in_tag), .ray_in_isShadow(ray_in_isShadow),
      .sint_ray(sint_ray), .sint_v0(sint_v0), .sint_v1(sint_v1), .sint_v2(sint_v2),
      .sint_isShadow(sint_isShadow), .sint_tmin(sint_tmin), .sint_tmax(sint_tmax),
      .sint_miss(sint_miss),
      .hit_valid(hit_valid), .hit_stall(hit_stall), .hit_tag(hit_tag), .hit_tmin(hit_tmin),
      .hit_tmax(hit_tmax), .hit_isShadow(hit_isShadow),
      .miss_valid(miss_valid), .miss_stall(miss_stall), .miss_tag(miss_tag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0]  tag;
      logic        miss;
      logic        shadow;
      logic [31:0] tmin;
      logic [31:0] tmax;
   } exp_t;

   exp_t exp_q[$];
   int   out_cyc_q[$];
   int   acc_cnt = 0;
   int   last_acc = 0;

   // Pipeline model: result fields are carried in the ray payload and appear LAT cycles after the x issue.
   logic [LAT-1:0]   pv = '0;
   logic [RAY_W-1:0] pr [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], sint_v0};
      pr[0] <= sint_ray;
      for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
   end
   assign sint_tmin = pv[LAT-1] ? pr[LAT-1][31:0]  : 32'hDEAD_BEEF;
   assign sint_tmax = pv[LAT-1] ? pr[LAT-1][63:32] : 32'hBAAD_F00D;
   assign sint_miss = pv[LAT-1] ? pr[LAT-1][64]    : 1'b1;

   function automatic logic [RAY_W-1:0] mk_ray(input logic [7:0] tag, input logic miss,
                                               input logic [31:0] tmin, input logic [31:0] tmax);
      logic [RAY_W-1:0] r;
      r = '0;
      r[31:0]  = tmin;
      r[63:32] = tmax;
      r[64]    = miss;
      r[RAY_W-1 -: 8] = tag;
      return r;
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks data holds while stalled.
   logic [72:0] prev_h;
   logic [7:0]  prev_m;
   logic        hold_h = 1'b0, hold_m = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_h = 1'b0;
         hold_m = 1'b0;
      end else begin
         if (hit_valid && miss_valid) check("both_valid", 80'd1, 80'd0);
         if (hit_valid && hit_stall) begin
            if (hold_h) check("hit_hold", {hit_tag, hit_isShadow, hit_tmin, hit_tmax}, prev_h);
            hold_h = 1'b1;
            prev_h = {hit_tag, hit_isShadow, hit_tmin, hit_tmax};
         end else hold_h = 1'b0;
         if (miss_valid && miss_stall) begin
            if (hold_m) check("miss_hold", miss_tag, prev_m);
            hold_m = 1'b1;
            prev_m = miss_tag;
         end else hold_m = 1'b0;
         if (hit_valid && !hit_stall) begin
            if (exp_q.size() == 0) check("hit_unexpected", {8'd0, hit_tag}, 80'hFFFF);
            else begin
               e = exp_q.pop_front();
               check("hit_result", {hit_tag, 1'b0, hit_isShadow, hit_tmin, hit_tmax}, e);
            end
            out_cyc_q.push_back(cyc);
         end
         if (miss_valid && !miss_stall) begin
            if (exp_q.size() == 0) check("miss_unexpected", {8'd0, miss_tag}, 80'hFFFF);
            else begin
               e = exp_q.pop_front();
               check("miss_result", {miss_tag, 1'b1}, {e.tag, e.miss});
            end
            out_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic send(input logic [7:0] tag, input logic shadow, input logic miss,
                       input logic [31:0] tmin, input logic [31:0] tmax, input int bound);
      exp_t e;
      bit   ok;
      ray_in_valid    = 1'b1;
      ray_in          = mk_ray(tag, miss, tmin, tmax);
      ray_in_tag      = tag;
      ray_in_isShadow = shadow;
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!ray_in_stall) begin
            e.tag = tag; e.miss = miss; e.shadow = shadow; e.tmin = tmin; e.tmax = tmax;
            exp_q.push_back(e);
            last_acc = cyc;
            acc_cnt++;
            ok = 1;
            @(posedge clk); #1;
            break;
         end
      end
      if (!ok) check("accept_timeout", {72'd0, tag}, 80'hFFFF);
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !hit_valid && !miss_valid) break;
      end
      check("drain_empty", exp_q.size(), 80'd0);
      @(posedge clk); #1;
   endtask

   int acc_t[4];

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RAY_W-1:0] r;
      rst = 1'b1; ray_in_valid = 1'b0; ray_in = '0; ray_in_tag = '0; ray_in_isShadow = 1'b0;
      hit_stall = 1'b0; miss_stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {sint_v0, sint_v1, sint_v2, hit_valid, miss_valid, sint_isShadow, ray_in_stall}, 80'd0);
      check("reset_ray", {79'd0, |sint_ray}, 80'd0);
      check("reset_credits", dut.credits, 80'd8);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single hit ray: issue sequence and exact latency.
      out_cyc_q.delete();
      send(8'h05, 1'b0, 1'b0, 32'h3F00_0000, 32'h3F80_0000, 50);
      ray_in_valid = 1'b0;
      r = mk_ray(8'h05, 1'b0, 32'h3F00_0000, 32'h3F80_0000);
      check("t1_axis_x", {sint_v0, sint_v1, sint_v2}, 80'b100);
      check("t1_sint_ray", sint_ray[79:0], r[79:0]);
      @(posedge clk); #1;
      check("t1_axis_y", {sint_v0, sint_v1, sint_v2}, 80'b010);
      @(posedge clk); #1;
      check("t1_axis_z", {sint_v0, sint_v1, sint_v2}, 80'b001);
      wait_drain(60);
      check("t1_out_count", out_cyc_q.size(), 80'd1);
      if (out_cyc_q.size() >= 1) check("t1_latency", out_cyc_q[0] - last_acc, LAT + 2);

      // Back-to-back rays: one accept every 3 cycles, outputs 3 cycles apart.
      out_cyc_q.delete();
      for (int t = 0; t < 4; t++) begin
         send(8'(t + 1), t[0], 1'b0, 32'h4000_0000 + t, 32'h4100_0000 + t, 50);
         acc_t[t] = last_acc;
      end
      ray_in_valid = 1'b0;
      for (int t = 1; t < 4; t++) check("t2_accept_gap", acc_t[t] - acc_t[t-1], 80'd3);
      wait_drain(80);
      check("t2_out_count", out_cyc_q.size(), 80'd4);
      if (out_cyc_q.size() == 4)
         for (int t = 1; t < 4; t++) check("t2_out_gap", out_cyc_q[t] - out_cyc_q[t-1], 80'd3);

      // Credit exhaustion under hit_stall.
      out_cyc_q.delete();
      hit_stall = 1'b1;
      acc_cnt = 0;
      fork
         begin
            for (int t = 0; t < 12; t++)
               send(8'h10 + 8'(t), 1'b1, 1'b0, 32'h1000 + t, 32'h2000 + t, 400);
            ray_in_valid = 1'b0;
         end
         begin
            repeat (100) @(posedge clk);
            #1;
            check("t3_accepted", acc_cnt, 80'd8);
            @(negedge clk);
            check("t3_stall_high", ray_in_stall, 80'd1);
            @(posedge clk); #1;
            hit_stall = 1'b0;
         end
      join
      wait_drain(300);
      check("t3_out_count", out_cyc_q.size(), 80'd12);

      // Hit/miss ordering with a stalled miss.
      out_cyc_q.delete();
      miss_stall = 1'b1;
      send(8'h01, 1'b0, 1'b0, 32'h0111, 32'h0222, 50);
      send(8'h02, 1'b1, 1'b1, 32'h0333, 32'h0444, 50);
      send(8'h03, 1'b0, 1'b0, 32'h0555, 32'h0666, 50);
      ray_in_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (miss_valid) break;
      end
      check("t4_miss_seen", miss_valid, 80'd1);
      check("t4_hit1_first", out_cyc_q.size(), 80'd1);
      repeat (20) begin
         @(negedge clk);
         check("t4_blocked", {miss_valid, hit_valid, miss_tag}, {8'd0, 1'b1, 1'b0, 8'h02});
      end
      @(posedge clk); #1;
      miss_stall = 1'b0;
      wait_drain(40);
      check("t4_out_count", out_cyc_q.size(), 80'd3);

      // Reset in AX_Y with three rays in flight.
      out_cyc_q.delete();
      send(8'h21, 1'b0, 1'b0, 32'hA1, 32'hB1, 50);
      send(8'h22, 1'b0, 1'b1, 32'hA2, 32'hB2, 50);
      send(8'h23, 1'b1, 1'b0, 32'hA3, 32'hB3, 50);
      ray_in_valid = 1'b0;
      @(posedge clk); #1;
      check("t5_in_axis_y", sint_v1, 80'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t5_outputs_clear", {sint_v0, sint_v1, sint_v2, hit_valid, miss_valid}, 80'd0);
      check("t5_credits", dut.credits, 80'd8);
      check("t5_dl_clear", dut.dl_valid, 80'd0);
      exp_q.delete();
      rst = 1'b0;
      repeat (LAT + 10) @(posedge clk);
      #1;
      check("t5_no_stale", out_cyc_q.size(), 80'd0);
      send(8'h30, 1'b1, 1'b0, 32'h3F40_0000, 32'h4000_0000, 50);
      ray_in_valid = 1'b0;
      wait_drain(60);
      check("t5_new_ray", out_cyc_q.size(), 80'd1);

      // Concurrent accept and pop at credits=1.
      out_cyc_q.delete();
      hit_stall = 1'b1;
      for (int t = 0; t < 7; t++) send(8'h40 + 8'(t), 1'b0, 1'b0, 32'h600 + t, 32'h700 + t, 50);
      ray_in_valid = 1'b0;
      repeat (LAT + 10) @(posedge clk);
      #1;
      check("t6_credits_one", dut.credits, 80'd1);
      ray_in_valid = 1'b1;
      ray_in = mk_ray(8'h47, 1'b0, 32'h647, 32'h747);
      ray_in_tag = 8'h47;
      ray_in_isShadow = 1'b0;
      hit_stall = 1'b0;
      @(negedge clk);
      check("t6_accept_and_pop", {ray_in_stall, hit_valid}, 80'b01);
      begin
         exp_t e;
         e.tag = 8'h47; e.miss = 1'b0; e.shadow = 1'b0; e.tmin = 32'h647; e.tmax = 32'h747;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      hit_stall = 1'b1;
      ray_in_valid = 1'b0;
      check("t6_credits_held", dut.credits, 80'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_next_window", {sint_v2, ray_in_stall}, 80'b10);
      @(posedge clk); #1;
      hit_stall = 1'b0;
      wait_drain(80);
      check("t6_out_count", out_cyc_q.size(), 80'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
